div_16x8_seq: RTL

Sequential restoring divider that is the inverse of the 8x8 multiplier family. It takes a 16-bit product-width dividend and an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder. Any exact 8x8 product R = A*B with B != 0 divides back to Q = A, Rem = 0. It sits behind the multiplier datapath for result checking and reciprocal paths, uses valid/ready handshakes on both sides, and produces one quotient bit per clock.

---
 rtl/div_16x8_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/div_16x8_seq.sv
// div_16x8_seq: sequential restoring divider, 16-bit dividend / 8-bit divisor.
// Latency: 9 edges from accept to out_valid on the normal path; 1 edge for
//   divide-by-zero or quotient overflow.
// Backpressure: results are held in DONE until out_ready; in_ready is high in IDLE only.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (A dividend, B divisor)
//   out_valid/out_ready  result handshake (Q quotient, Rem remainder, ovf, dz flags)
module div_16x8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Q,
  output logic [7:0]  Rem,
  output logic        ovf,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_r;   // captured divisor
  logic [7:0]  r;       // partial remainder; always < divisor, so 8 bits suffice
  logic [7:0]  d;       // dividend low byte shifting out, quotient bits shifting in
  logic [2:0]  cnt;     // step counter, 0..7

  logic [8:0]  t;
  logic        q_bit;
  logic [7:0]  r_nxt;
  logic        special;
  logic        accept;

  // One restoring step: bring down the next dividend bit and try a subtract.
  // Since r < divisor, t <= 509 and the 9-bit compare cannot overflow.
  always_comb begin
    t       = {r, d[7]};
    q_bit   = (t >= {1'b0, div_r});
    r_nxt   = q_bit ? 8'(t - {1'b0, div_r}) : t[7:0];
    // High byte >= divisor means the quotient needs more than 8 bits.
    // B == 0 is covered by the same compare, but is listed for clarity.
    special = (B == 8'd0) || (A[15:8] >= B);
    accept  = in_valid && (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == 3'd7) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Result registers are written only when a result is produced,
  // so they stay stable through DONE and keep their value in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= 8'd0;
      r     <= 8'd0;
      d     <= 8'd0;
      cnt   <= 3'd0;
      Q     <= 8'd0;
      Rem   <= 8'd0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else if (accept) begin
      div_r <= B;
      r     <= A[15:8];
      d     <= A[7:0];
      cnt   <= 3'd0;
      if (special) begin
        Q   <= 8'hFF;
        Rem <= 8'hFF;
        ovf <= 1'b1;
        dz  <= (B == 8'd0);
      end
    end else if (state == CALC) begin
      r   <= r_nxt;
      d   <= {d[6:0], q_bit};
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        Q   <= {d[6:0], q_bit};
        Rem <= r_nxt;
        ovf <= 1'b0;
        dz  <= 1'b0;
      end
    end
  end

endmodule
